interrupt_controller: RTL and testbench

Platform interrupt controller that collects up to 31 external level-sensitive interrupt sources, synchronizes them, and holds per-source pending and in-service state. It arbitrates by programmable priority and raises a single machine external interrupt line. That line is wired to bit 16 of the exception unit's synchronized interrupt vector. Software configures the block and runs the claim/complete handshake through a single-cycle memory-mapped register port.

---
 rtl/common_types_pkg.sv | 19 +
 rtl/interrupt_controller_if.sv | 18 +
 rtl/irq_arbiter.sv | 26 ++
 rtl/interrupt_controller.sv | 136 +++++++++++++
 tb/tb_interrupt_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_types_pkg.sv
// Shared types and register map constants for the platform interrupt controller.
package common_types_pkg;

  // Register word offsets
  localparam logic [2:0] IC_ENABLE    = 3'd0;
  localparam logic [2:0] IC_PENDING   = 3'd1;
  localparam logic [2:0] IC_THRESHOLD = 3'd2;
  localparam logic [2:0] IC_CLAIM     = 3'd3;
  localparam logic [2:0] IC_PRIO0     = 3'd4;
  localparam logic [2:0] IC_PRIO1     = 3'd5;
  localparam logic [2:0] IC_PRIO2     = 3'd6;
  localparam logic [2:0] IC_PRIO3     = 3'd7;

  localparam int IC_PRIO_W = 4;

  typedef logic [3:0] ic_prio_t;
  typedef logic [4:0] ic_id_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Single-cycle register port of the interrupt controller.
interface interrupt_controller_if;
  logic [2:0]  reg_addr;
  logic        reg_wen;
  logic        reg_ren;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_addr, reg_wen, reg_ren, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wen, reg_ren, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/irq_arbiter.sv
// Combinational selector: highest priority candidate wins, ties to the lowest ID.
// A winner must have a non-zero priority; with no winner both outputs are 0.
module irq_arbiter
  import common_types_pkg::*;
#(
  parameter int NUM_SRC = 32
) (
  input  logic     [NUM_SRC-1:0] cand_i,
  input  ic_prio_t [NUM_SRC-1:0] prio_i,
  output ic_id_t                 win_id_o,
  output ic_prio_t               win_prio_o
);

  // Scan upward with a strict compare so an equal priority never displaces a lower ID.
  always_comb begin
    win_id_o   = '0;
    win_prio_o = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (cand_i[n] && (prio_i[n] > win_prio_o)) begin
        win_id_o   = ic_id_t'(n);
        win_prio_o = prio_i[n];
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Platform interrupt controller: level gateways, pending/in-service tracking,
// priority arbitration and the claim/complete register handshake.
module interrupt_controller
  import common_types_pkg::*;
#(
  parameter int NUM_SRC = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NUM_SRC-1:0]     irq_in,
  interrupt_controller_if.slave  bus,
  output logic                   ext_irq,
  output ic_id_t                 claim_id
);

  // Source 0 is reserved; this mask keeps all of its state bits at zero.
  localparam logic [NUM_SRC-1:0] SRC_MASK = {{(NUM_SRC-1){1'b1}}, 1'b0};

  logic     [NUM_SRC-1:0] sync1_q, sync2_q;
  logic     [NUM_SRC-1:0] pending_q, pending_d;
  logic     [NUM_SRC-1:0] in_service_q, in_service_d;
  logic     [NUM_SRC-1:0] enable_q, enable_d;
  ic_prio_t               threshold_q, threshold_d;
  ic_prio_t [NUM_SRC-1:0] prio_q, prio_d;
  ic_id_t                 claim_id_q;
  logic                   ext_irq_q;

  logic     [NUM_SRC-1:0] cand;
  ic_id_t                 win_id;
  ic_prio_t               win_prio;

  logic claim_rd, complete_wr;

  assign claim_rd    = bus.reg_ren && (bus.reg_addr == IC_CLAIM);
  assign complete_wr = bus.reg_wen && (bus.reg_addr == IC_CLAIM);

  // Candidate filter: pending, enabled and strictly above threshold.
  always_comb begin
    cand = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      cand[n] = pending_q[n] && enable_q[n] && (prio_q[n] > threshold_q);
    end
  end

  irq_arbiter #(.NUM_SRC(NUM_SRC)) u_arbiter (
    .cand_i     (cand),
    .prio_i     (prio_q),
    .win_id_o   (win_id),
    .win_prio_o (win_prio)
  );

  // Read mux works on registered state only, so a same-cycle write is not visible yet.
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      IC_ENABLE:    bus.reg_rdata[NUM_SRC-1:0] = enable_q;
      IC_PENDING:   bus.reg_rdata[NUM_SRC-1:0] = pending_q;
      IC_THRESHOLD: bus.reg_rdata[3:0]         = threshold_q;
      IC_CLAIM:     bus.reg_rdata[4:0]         = claim_id_q;
      default: begin
        for (int n = 0; n < NUM_SRC; n++) begin
          if (bus.reg_addr[1:0] == 2'(n / 8)) begin
            bus.reg_rdata[(n % 8)*IC_PRIO_W +: IC_PRIO_W] = prio_q[n];
          end
        end
      end
    endcase
  end

  // Next-state: gateway set, then claim, then complete, so later terms override earlier ones.
  always_comb begin
    enable_d     = enable_q;
    threshold_d  = threshold_q;
    prio_d       = prio_q;
    in_service_d = in_service_q;
    pending_d    = pending_q | (sync2_q & ~in_service_q & SRC_MASK);

    if (claim_rd) begin
      for (int n = 1; n < NUM_SRC; n++) begin
        if (claim_id_q == ic_id_t'(n)) begin
          pending_d[n]    = 1'b0;
          in_service_d[n] = 1'b1;
        end
      end
    end

    if (bus.reg_wen) begin
      case (bus.reg_addr)
        IC_ENABLE:    enable_d    = bus.reg_wdata[NUM_SRC-1:0] & SRC_MASK;
        IC_THRESHOLD: threshold_d = bus.reg_wdata[3:0];
        IC_CLAIM: begin
          for (int n = 1; n < NUM_SRC; n++) begin
            if (bus.reg_wdata[4:0] == ic_id_t'(n)) in_service_d[n] = 1'b0;
          end
        end
        IC_PRIO0, IC_PRIO1, IC_PRIO2, IC_PRIO3: begin
          for (int n = 1; n < NUM_SRC; n++) begin
            if (bus.reg_addr[1:0] == 2'(n / 8)) begin
              prio_d[n] = bus.reg_wdata[(n % 8)*IC_PRIO_W +: IC_PRIO_W];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; ext_irq tracks the winner priority, which is non-zero exactly when an ID wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      threshold_q  <= '0;
      prio_q       <= '0;
      claim_id_q   <= '0;
      ext_irq_q    <= 1'b0;
    end else begin
      sync1_q      <= irq_in;
      sync2_q      <= sync1_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      prio_q       <= prio_d;
      claim_id_q   <= win_id;
      ext_irq_q    <= (win_prio != '0);
    end
  end

  assign ext_irq  = ext_irq_q;
  assign claim_id = claim_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized checks of interrupt_controller with NUM_SRC=16.
module tb_interrupt_controller;
  import common_types_pkg::*;

  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NS-1:0] irq_in = '0;
  logic          ext_irq;
  ic_id_t        claim_id;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NS-1:0] en_m, pend_m, ins_m, lvl_m;
  int            prio_m [NS];
  int            thr_m;

  interrupt_controller_if bus ();

  interrupt_controller #(.NUM_SRC(NS)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .irq_in   (irq_in),
    .bus      (bus),
    .ext_irq  (ext_irq),
    .claim_id (claim_id)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wen = 1'b1;
    @(negedge clk);
    bus.reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_ren = 1'b1;
    #1 d = bus.reg_rdata;
    @(negedge clk);
    bus.reg_ren = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_wdata = wd; bus.reg_wen = 1'b1; bus.reg_ren = 1'b1;
    #1 d = bus.reg_rdata;
    @(negedge clk);
    bus.reg_wen = 1'b0; bus.reg_ren = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1 d = bus.reg_rdata;
  endtask

  // Winner by ranking key: priority first, then the smaller ID.
  function automatic int model_win();
    int best_key = -1;
    int best_id  = 0;
    for (int id = 1; id < NS; id++) begin
      if (pend_m[id] && en_m[id] && prio_m[id] > thr_m && prio_m[id] > 0) begin
        if (prio_m[id] * 64 + (63 - id) > best_key) begin
          best_key = prio_m[id] * 64 + (63 - id);
          best_id  = id;
        end
      end
    end
    return best_id;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] w0, w1;
    int          w, cid;
    int          q[$];

    bus.reg_addr = '0; bus.reg_wen = 1'b0; bus.reg_ren = 1'b0; bus.reg_wdata = '0;

    // Reset and idle
    cyc(3);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("idle_ext_irq", ext_irq, 0);
      chk("idle_claim_id", claim_id, 0);
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("reset_rd%0d", a), d, 0);
    end

    // Reserved bit 0, bits above NS, unused priority words
    wr(IC_ENABLE, 32'hFFFF_FFFF);
    rd(IC_ENABLE, d);     chk("enable_mask", d, 32'h0000_FFFE);
    wr(IC_PRIO0, 32'h0030_000F);
    rd(IC_PRIO0, d);      chk("prio0_rd", d, 32'h0030_0000);
    wr(IC_PRIO2, 32'hFFFF_FFFF);
    rd(IC_PRIO2, d);      chk("prio2_rd", d, 0);
    rd(IC_PRIO1, d);      chk("prio1_rd", d, 0);
    wr(IC_THRESHOLD, 32'h0000_003A);
    rd(IC_THRESHOLD, d);  chk("thr_rd", d, 32'hA);
    wr(IC_THRESHOLD, 0);
    wr(IC_ENABLE, 32'h20);

    // One-cycle pulse on source 5: latency and claim
    irq_in[5] = 1'b1;
    cyc(1);
    irq_in[5] = 1'b0;
    cyc(2);
    chk("lat_e3_ext_irq", ext_irq, 0);
    cyc(1);
    chk("lat_e4_ext_irq", ext_irq, 1);
    chk("lat_e4_claim_id", claim_id, 5);
    rd(IC_CLAIM, d);
    chk("claim5", d, 5);
    chk("claim5_ext_t1", ext_irq, 1);
    cyc(1);
    chk("claim5_ext_t2", ext_irq, 0);
    peek(IC_PENDING, d);  chk("claim5_pending", d, 0);
    wr(IC_CLAIM, 5);
    cyc(4);
    chk("after_c5_ext", ext_irq, 0);

    // Claim and complete of the same ID in one cycle
    irq_in[5] = 1'b1;
    cyc(1);
    irq_in[5] = 1'b0;
    cyc(4);
    rw(IC_CLAIM, 5, d);
    chk("rw_claim", d, 5);
    cyc(1);
    chk("rw_ext", ext_irq, 0);
    peek(IC_PENDING, d);  chk("rw_pending", d, 0);
    irq_in[5] = 1'b1;
    cyc(1);
    irq_in[5] = 1'b0;
    cyc(4);
    chk("rw_repend_claim_id", claim_id, 5);
    rd(IC_CLAIM, d);      chk("rw_reclaim", d, 5);
    wr(IC_CLAIM, 5);

    // Priority ordering and tie-break
    wr(IC_PRIO0, 32'h0030_2000);
    wr(IC_PRIO1, 32'h0000_0070);
    wr(IC_ENABLE, 32'h0000_0228);
    irq_in[3] = 1'b1; irq_in[9] = 1'b1;
    cyc(1);
    irq_in[3] = 1'b0; irq_in[9] = 1'b0;
    cyc(4);
    rd(IC_CLAIM, d);      chk("prio_claim9", d, 9);
    cyc(1);
    chk("prio_next3", claim_id, 3);
    rd(IC_CLAIM, d);      chk("prio_claim3", d, 3);
    wr(IC_CLAIM, 9);
    wr(IC_CLAIM, 3);
    wr(IC_PRIO1, 32'h0000_0020);
    irq_in[3] = 1'b1; irq_in[9] = 1'b1;
    cyc(1);
    irq_in[3] = 1'b0; irq_in[9] = 1'b0;
    cyc(4);
    rd(IC_CLAIM, d);      chk("tie_claim3", d, 3);
    cyc(1);
    rd(IC_CLAIM, d);      chk("tie_claim9", d, 9);
    wr(IC_CLAIM, 3);
    wr(IC_CLAIM, 9);
    cyc(3);
    chk("tie_done_ext", ext_irq, 0);

    // Threshold gating and write-to-effect latency
    wr(IC_PRIO1, 32'h0000_0070);
    wr(IC_THRESHOLD, 7);
    irq_in[9] = 1'b1;
    cyc(1);
    irq_in[9] = 1'b0;
    cyc(5);
    chk("thr7_ext", ext_irq, 0);
    peek(IC_PENDING, d);  chk("thr7_pending", d, 32'h200);
    wr(IC_THRESHOLD, 6);
    chk("thr6_ext_e1", ext_irq, 0);
    cyc(1);
    chk("thr6_ext_e2", ext_irq, 1);
    rd(IC_CLAIM, d);      chk("thr6_claim", d, 9);
    wr(IC_CLAIM, 9);
    wr(IC_THRESHOLD, 0);

    // Held level: no re-pend while in service, re-pend after complete
    wr(IC_PRIO0, 32'h0031_2000);
    wr(IC_ENABLE, 32'h0000_0238);
    irq_in[4] = 1'b1;
    cyc(5);
    chk("hold_claim_id", claim_id, 4);
    rd(IC_CLAIM, d);      chk("hold_claim4", d, 4);
    cyc(4);
    peek(IC_PENDING, d);  chk("hold_no_repend", d, 0);
    chk("hold_ext", ext_irq, 0);
    wr(IC_CLAIM, 0);
    wr(IC_CLAIM, 31);
    wr(IC_CLAIM, 20);
    cyc(4);
    peek(IC_PENDING, d);  chk("bad_complete_pending", d, 0);
    chk("bad_complete_ext", ext_irq, 0);
    wr(IC_CLAIM, 4);
    peek(IC_PENDING, d);  chk("c4_pending_e1", d, 0);
    cyc(1);
    peek(IC_PENDING, d);  chk("c4_pending_e2", d, 32'h10);
    cyc(1);
    chk("c4_ext_back", ext_irq, 1);
    rd(IC_CLAIM, d);      chk("c4_reclaim", d, 4);

    // Reset while source 4 is in service
    nrst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("midrst_rd%0d", a), d, 0);
    end
    chk("midrst_ext", ext_irq, 0);
    chk("midrst_claim_id", claim_id, 0);
    nrst = 1'b1;
    cyc(2);
    peek(IC_PENDING, d);  chk("rel_pending_e2", d, 0);
    cyc(1);
    peek(IC_PENDING, d);  chk("rel_pending_e3", d, 32'h10);
    chk("rel_ext_disabled", ext_irq, 0);
    wr(IC_ENABLE, 32'h10);
    wr(IC_PRIO0, 32'h0001_0000);
    chk("rel_ext_e1", ext_irq, 0);
    cyc(1);
    chk("rel_ext_e2", ext_irq, 1);
    rd(IC_CLAIM, d);      chk("rel_claim4", d, 4);
    irq_in = '0;
    wr(IC_CLAIM, 4);

    // Randomized phase against the reference model
    nrst = 1'b0;
    cyc(2);
    nrst = 1'b1;
    en_m = '0; pend_m = '0; ins_m = '0; lvl_m = '0; thr_m = 0;
    for (int i = 0; i < NS; i++) prio_m[i] = 0;

    for (int it = 0; it < 40; it++) begin
      d = $urandom;
      wr(IC_ENABLE, d);
      en_m = d[NS-1:0] & 16'hFFFE;
      thr_m = $urandom_range(0, 3);
      wr(IC_THRESHOLD, ($urandom & 32'hFFFF_FFF0) | 32'(thr_m));
      w0 = $urandom; w1 = $urandom;
      wr(IC_PRIO0, w0);
      wr(IC_PRIO1, w1);
      for (int n = 1; n < NS; n++) begin
        prio_m[n] = (n < 8) ? int'((w0 >> (4 * n)) & 32'hF) : int'((w1 >> (4 * (n - 8))) & 32'hF);
      end

      cyc(1);
      lvl_m  = 16'($urandom) & 16'hFFFE;
      irq_in = lvl_m;
      cyc(5);
      pend_m = pend_m | (lvl_m & ~ins_m);

      w = model_win();
      peek(IC_PENDING, d);
      chk("rnd_pending", d, {16'h0, pend_m});
      chk("rnd_claim_id", claim_id, 32'(w));
      chk("rnd_ext", ext_irq, (w != 0) ? 1 : 0);
      rd(IC_CLAIM, d);
      chk("rnd_claim", d, 32'(w));
      if (w != 0) begin
        pend_m[w] = 1'b0;
        ins_m[w]  = 1'b1;
      end
      cyc(3);

      q.delete();
      for (int n = 1; n < NS; n++) if (ins_m[n]) q.push_back(n);
      if (q.size() != 0 && $urandom_range(0, 3) != 0) cid = q[$urandom_range(0, q.size() - 1)];
      else cid = $urandom_range(0, 31);
      wr(IC_CLAIM, ($urandom & 32'hFFFF_FFE0) | 32'(cid));
      if (cid >= 1 && cid < NS) ins_m[cid] = 1'b0;
      cyc(4);
      pend_m = pend_m | (lvl_m & ~ins_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
